// File: rtl/uart_rx_deframer_if.sv
// Serial line, per-frame configuration and deframed word/status of uart_rx_deframer.
// master = line/config driver and word consumer, slave = the deframer itself.
interface uart_rx_deframer_if #(
    parameter int unsigned DATA_WIDTH = 8
);

    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  parity_error;
    logic                  stop_error;
    logic                  busy;

    modport master (
        output RX_IN,
        output PAR_EN,
        output PAR_TYP,
        input  P_DATA,
        input  data_valid,
        input  parity_error,
        input  stop_error,
        input  busy
    );

    modport slave (
        input  RX_IN,
        input  PAR_EN,
        input  PAR_TYP,
        output P_DATA,
        output data_valid,
        output parity_error,
        output stop_error,
        output busy
    );

endinterface

// File: rtl/uart_rx_deframer.sv
// Oversampling UART receive deframer: start / DATA_WIDTH data (LSB first) / optional parity / stop.
// Define UART_RX_MAJORITY_VOTE_EN for a 2-of-3 vote around mid-bit instead of a single sample.
module uart_rx_deframer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic                CLK,
    input  logic                RST,
    uart_rx_deframer_if.slave   rx
);

    localparam int unsigned H   = OVERSAMPLE / 2;
    localparam int unsigned EcW = $clog2(OVERSAMPLE);
    localparam int unsigned BcW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [EcW-1:0] EcMid  = EcW'(H);
    localparam logic [EcW-1:0] EcDec  = EcW'(H + 1);
    localparam logic [EcW-1:0] EcLast = EcW'(OVERSAMPLE - 1);
    localparam logic [BcW-1:0] BitLast = BcW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic [EcW-1:0]        edge_cnt_q, edge_cnt_d;
    logic [BcW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_err_q, par_err_d;
    logic                  done_q, done_d;
    logic                  stop_bad_q, stop_bad_d;
    logic                  samp_mid_q, samp_mid_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  stop_error_q, stop_error_d;

    logic                  decision;
    logic                  dec_edge;
    logic                  last_edge;
    logic [EcW-1:0]        edge_nxt;
    logic                  exp_par;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [EcW-1:0] EcLo = EcW'(H - 1);

    logic samp_lo_q, samp_lo_d;

    // Third vote is the live line on the decision edge itself.
    always_comb begin
        samp_lo_d = (edge_cnt_q == EcLo) ? rx.RX_IN : samp_lo_q;
        decision  = (samp_lo_q & samp_mid_q) | (samp_lo_q & rx.RX_IN) |
                    (samp_mid_q & rx.RX_IN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            samp_lo_q <= 1'b1;
        end else begin
            samp_lo_q <= samp_lo_d;
        end
    end
`else
    always_comb begin
        decision = samp_mid_q;
    end
`endif

    always_comb begin
        samp_mid_d = (edge_cnt_q == EcMid) ? rx.RX_IN : samp_mid_q;
        dec_edge   = (edge_cnt_q == EcDec);
        last_edge  = (edge_cnt_q == EcLast);
        edge_nxt   = last_edge ? '0 : edge_cnt_q + 1'b1;
        exp_par    = (^shift_q) ^ par_typ_q;
    end

    // Frame sequencing.
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_err_d  = par_err_q;
        done_d     = 1'b0;
        stop_bad_d = stop_bad_q;

        unique case (state_q)
            StIdle: begin
                // The detection cycle is edge 0 of the start bit.
                if (!rx.RX_IN) begin
                    state_d    = StStart;
                    edge_cnt_d = EcW'(1);
                    par_en_d   = rx.PAR_EN;
                    par_typ_d  = rx.PAR_TYP;
                    par_err_d  = 1'b0;
                end
            end
            StStart: begin
                edge_cnt_d = edge_nxt;
                if (dec_edge && decision) begin
                    state_d    = StIdle;
                    edge_cnt_d = '0;
                end else if (last_edge) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                edge_cnt_d = edge_nxt;
                if (dec_edge) begin
                    shift_d                 = shift_q >> 1;
                    shift_d[DATA_WIDTH-1]   = decision;
                end
                if (last_edge) begin
                    if (bit_cnt_q == BitLast) begin
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                edge_cnt_d = edge_nxt;
                if (dec_edge) begin
                    par_err_d = (decision != exp_par);
                end
                if (last_edge) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                edge_cnt_d = edge_nxt;
                // Leave half a bit early so a back-to-back start edge is not missed.
                if (dec_edge) begin
                    state_d    = StIdle;
                    edge_cnt_d = '0;
                    done_d     = 1'b1;
                    stop_bad_d = ~decision;
                end
            end
            default: begin
                state_d    = StIdle;
                edge_cnt_d = '0;
            end
        endcase
    end

    // Result pulses are registered one cycle after the stop decision.
    always_comb begin
        data_valid_d   = done_q & ~stop_bad_q & ~par_err_q;
        parity_error_d = done_q & par_err_q;
        stop_error_d   = done_q & stop_bad_q;
        p_data_d       = data_valid_d ? shift_q : p_data_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= StIdle;
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            par_err_q      <= 1'b0;
            done_q         <= 1'b0;
            stop_bad_q     <= 1'b0;
            samp_mid_q     <= 1'b1;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            par_en_q       <= par_en_d;
            par_typ_q      <= par_typ_d;
            par_err_q      <= par_err_d;
            done_q         <= done_d;
            stop_bad_q     <= stop_bad_d;
            samp_mid_q     <= samp_mid_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    assign rx.P_DATA       = p_data_q;
    assign rx.data_valid   = data_valid_q;
    assign rx.parity_error = parity_error_q;
    assign rx.stop_error   = stop_error_q;
    assign rx.busy         = (state_q != StIdle);

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Receive-side counterpart of the UART TX path. It samples the serial line with an oversampling clock and deframes start / DATA_WIDTH data (LSB first) / optional parity / stop. It delivers a parallel word with a one-cycle valid pulse, or an error pulse. It sits between the external RX pin (already synchronized upstream) and the system's RX data consumer.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
OVERSAMPLE, 8, CLK cycles per bit; even, >= 4; H = OVERSAMPLE/2

Ports:
CLK  in  1  oversampling clock, OVERSAMPLE x baud
RST  in  1  asynchronous, active-high reset
RX_IN  in  1  serial line, idle high, already synchronous to CLK
PAR_EN  in  1  1 = frame carries a parity bit
PAR_TYP  in  1  0 = even, 1 = odd parity
P_DATA  out  DATA_WIDTH  last good received word
data_valid  out  1  one-cycle pulse, P_DATA updated
parity_error  out  1  one-cycle pulse, parity mismatch
stop_error  out  1  one-cycle pulse, stop bit sampled low
busy  out  1  frame reception in progress

Behaviour:
- Reset (async, RST=1): state IDLE, all counters 0, P_DATA=0, data_valid=parity_error=stop_error=busy=0. Reset mid-frame aborts the frame with no pulse. Reception restarts only on a new falling edge after RST deasserts.
- Counters:
  - edge_cnt, 0..OVERSAMPLE-1: position within the current bit.
  - bit_cnt, 0..DATA_WIDTH-1.
- Bit decision: sampled value resolved on the edge where edge_cnt==H+1 (see optional feature). Stop bit uses the same decision point.
- States:
  - IDLE:
    - RX_IN==0 -> START. That detection cycle counts as edge 0, so edge_cnt=1 next cycle.
    - PAR_EN and PAR_TYP are latched on this edge and held for the frame.
    - busy goes 1 on this edge.
  - START:
    - Decision==1 (glitch) -> IDLE, busy->0, no pulses.
    - Otherwise, at edge_cnt==OVERSAMPLE-1 -> DATA, edge_cnt=0, bit_cnt=0.
  - DATA:
    - Each decision shifts the bit in, LSB first, into an internal shift register.
    - At edge_cnt==OVERSAMPLE-1: if bit_cnt==DATA_WIDTH-1 -> PARITY (latched PAR_EN=1) or STOP; else bit_cnt+1.
  - PARITY:
    - Decision compared against expected = XOR(shift reg) XOR latched PAR_TYP; the mismatch flag is held internally.
    - At edge_cnt==OVERSAMPLE-1 -> STOP.
  - STOP: on the decision edge, go straight to IDLE (half-bit early, for back-to-back frame resync) and set busy->0. The registered pulses in the next cycle are:
    - Stop decision 0 -> stop_error=1.
    - Parity mismatch -> parity_error=1; both errors may pulse together.
    - No error -> P_DATA <= shift reg, data_valid=1.
    - P_DATA is unchanged on any error.
- Latency: data_valid is high exactly N = (1+DATA_WIDTH+PE)*OVERSAMPLE + H + 2 CLK edges after the detection edge (PE=latched PAR_EN). Default no parity gives N=78.
- Pulses last exactly one cycle. A new start may be detected in the same cycle a pulse is high.
- PAR_EN and PAR_TYP changes mid-frame are ignored.

Optional Feature:
Macro UART_RX_MAJORITY_VOTE_EN.
- Defined: RX_IN is sampled at edge_cnt H-1, H, H+1, and the decision is the 2-of-3 majority (third sample taken combinationally on the decision edge). A single-cycle line glitch is rejected.
- Undefined: only the sample at edge_cnt==H is used, registered and applied at H+1. Decision timing is identical, so latency does not change.

Test Plan:
- PAR_EN=0, frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), stop=1 -> data_valid pulse at N=78, P_DATA=0xA5, no error pulses.
- PAR_EN=1, PAR_TYP=0, frame 0x3C with parity bit 0 -> data_valid at N=86, P_DATA=0x3C. Same frame with parity bit 1 -> parity_error=1, data_valid=0, P_DATA keeps 0x3C.
- After a good 0xA5, frame 0x5A with stop bit held low -> stop_error pulse at N, P_DATA stays 0xA5, busy=0, then line returns high and remains IDLE.
- RX_IN low for 2 cycles then high -> START aborted at decision edge, busy pulses high then 0, no output pulses. Next full frame 0x01 received correctly.
- Two back-to-back frames 0x11, 0xEE (next start bit immediately after stop bit) -> two data_valid pulses 80 cycles apart, P_DATA 0x11 then 0xEE.
- RST=1 during DATA bit 4 -> all outputs 0 immediately. After release, a full frame 0x7E yields data_valid with P_DATA=0x7E. With the macro defined, a 1-cycle inverted glitch at edge_cnt==H of a data bit is ignored (value still 0x7E).
